// File: rtl/muldiv_if.sv
// Start/done command handshake between the execute stage and the multi-cycle
// multiply/divide unit.
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;
    logic [2:0]       op;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (output start, rd1, rd2, op, input busy, done, result);
    modport slave  (input start, rd1, rd2, op, output busy, done, result);
endinterface

// File: rtl/muldiv_unit.sv
// RISC-V M-extension multiply/divide: shift-add multiply and restoring divide
// on operand magnitudes, one bit per cycle, with signs fixed up on the last step.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst,
    muldiv_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state_reg, state_next;
    logic [2:0]         op_reg;
    logic               neg_a_reg, neg_b_reg;
    logic [WIDTH-1:0]   a_reg, b_reg;
    logic [2*WIDTH-1:0] acc_reg;
    logic [CW-1:0]      cnt_reg;
    logic               special_reg;
    logic [WIDTH-1:0]   special_res_reg;
    logic [WIDTH-1:0]   result_reg;

    logic               busy_state, done_state;

    // Capture-side decode
    logic               a_signed, b_signed, sa, sb;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic               div_zero, div_ovf, special;
    logic [WIDTH-1:0]   special_val;

    // Iteration datapath
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_step;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH-1:0]   rem_sub;
    logic               qbit;
    logic [2*WIDTH-1:0] div_step;
    logic [2*WIDTH-1:0] acc_step;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    logic [WIDTH-1:0]   final_result;

    always_comb begin
        a_signed = (bus.op == 3'b001) || (bus.op == 3'b010) ||
                   (bus.op == 3'b100) || (bus.op == 3'b110);
        b_signed = (bus.op == 3'b001) || (bus.op == 3'b100) || (bus.op == 3'b110);
        sa       = a_signed && bus.rd1[WIDTH-1];
        sb       = b_signed && bus.rd2[WIDTH-1];
        mag_a    = sa ? -bus.rd1 : bus.rd1;
        mag_b    = sb ? -bus.rd2 : bus.rd2;
        div_zero = bus.op[2] && (bus.rd2 == '0);
        div_ovf  = ((bus.op == 3'b100) || (bus.op == 3'b110)) &&
                   (bus.rd1 == MIN_NEG) && (bus.rd2 == '1);
        special  = div_zero || div_ovf;
        special_val = '0;
        if (div_zero)
            special_val = bus.op[1] ? bus.rd1 : '1;
        else if (div_ovf)
            special_val = bus.op[1] ? '0 : MIN_NEG;
    end

    always_comb begin
        // Multiply: add into the high half, then shift the whole product right
        mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (b_reg[0] ? {1'b0, a_reg} : '0);
        mul_step = {mul_sum, acc_reg[WIDTH-1:1]};

        // Divide: partial remainder in the high half, quotient grows in the low half
        rem_shift = {acc_reg[2*WIDTH-1:WIDTH], a_reg[WIDTH-1]};
        qbit      = (rem_shift >= {1'b0, b_reg});
        // The true difference is below the divisor, so the low bits are exact
        rem_sub   = qbit ? (rem_shift[WIDTH-1:0] - b_reg) : rem_shift[WIDTH-1:0];
        div_step  = {rem_sub, acc_reg[WIDTH-2:0], qbit};

        acc_step  = op_reg[2] ? div_step : mul_step;

        prod_fix = (neg_a_reg ^ neg_b_reg) ? -acc_step : acc_step;
        quo_fix  = (neg_a_reg ^ neg_b_reg) ? -acc_step[WIDTH-1:0] : acc_step[WIDTH-1:0];
        rem_fix  = neg_a_reg ? -acc_step[2*WIDTH-1:WIDTH] : acc_step[2*WIDTH-1:WIDTH];

        case (op_reg)
            3'b000:                 final_result = prod_fix[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: final_result = prod_fix[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         final_result = quo_fix;
            default:                final_result = rem_fix;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        busy_state = 1'b0;
        done_state = 1'b0;
        case (state_reg)
            IDLE: if (bus.start) state_next = CALC;
            CALC: begin
                busy_state = 1'b1;
                if (special_reg || (cnt_reg == '0)) state_next = DONE;
            end
            DONE: begin
                busy_state = 1'b1;
                done_state = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_reg          <= '0;
            neg_a_reg       <= 1'b0;
            neg_b_reg       <= 1'b0;
            a_reg           <= '0;
            b_reg           <= '0;
            acc_reg         <= '0;
            cnt_reg         <= '0;
            special_reg     <= 1'b0;
            special_res_reg <= '0;
            result_reg      <= '0;
        end else begin
            case (state_reg)
                IDLE: if (bus.start) begin
                    op_reg          <= bus.op;
                    neg_a_reg       <= sa;
                    neg_b_reg       <= sb;
                    a_reg           <= mag_a;
                    b_reg           <= mag_b;
                    acc_reg         <= '0;
                    cnt_reg         <= CW'(WIDTH - 1);
                    special_reg     <= special;
                    special_res_reg <= special_val;
                end
                CALC: begin
                    if (special_reg) begin
                        result_reg <= special_res_reg;
                    end else begin
                        acc_reg <= acc_step;
                        if (op_reg[2]) a_reg <= a_reg << 1;
                        else           b_reg <= b_reg >> 1;
                        if (cnt_reg == '0) result_reg <= final_result;
                        else               cnt_reg    <= cnt_reg - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy   = busy_state;
    assign bus.done   = done_state;
    assign bus.result = result_reg;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: a vector table of ops plus hand-written
// sequences for busy-time starts, held start and mid-operation reset.
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;

    muldiv_if #(.WIDTH(32)) bus ();

    muldiv_unit #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
        string       name;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Issue one op, optionally poke start with other operands at edge disturb_at,
    // then check latency, result, busy window and the single-cycle done pulse.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int exp_lat, input string name,
                          input int disturb_at);
        int lat;
        bit seen;
        bit busy_ok;
        @(negedge clk);
        bus.op = op; bus.rd1 = a; bus.rd2 = b; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.rd1 = $urandom; bus.rd2 = $urandom; bus.op = 3'($urandom);
        lat = 0; seen = 0; busy_ok = 1;
        while (!seen && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (!bus.busy) busy_ok = 0;
            if (bus.done) seen = 1;
            if (lat == disturb_at) begin
                bus.start = 1'b1; bus.op = 3'b101; bus.rd1 = 32'd100; bus.rd2 = 32'd3;
            end else begin
                bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        check({name, " latency"}, 32'(lat), 32'(exp_lat));
        check({name, " result"}, bus.result, exp);
        check({name, " busy window"}, 32'(busy_ok), 32'd1);
        @(posedge clk); #1;
        check({name, " done pulse width"}, {31'd0, bus.done}, 32'd0);
        check({name, " busy fall"}, {31'd0, bus.busy}, 32'd0);
        check({name, " result held"}, bus.result, exp);
        $display("[TB] %s op=%b a=%h b=%h -> result=%h latency=%0d", name, op, a, b, bus.result, lat);
    endtask

    task automatic wait_done(input string name, output int lat);
        lat = 0;
        while (lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (bus.done) break;
        end
        check({name, " done seen"}, {31'd0, bus.done}, 32'd1);
    endtask

    initial begin
        int lat;
        bit no_done;

        vecs[0]  = '{3'b000, 32'd9,        32'd10,       32'd90,       32, "MUL 9x10"};
        vecs[1]  = '{3'b001, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32, "MULH"};
        vecs[2]  = '{3'b011, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32, "MULHU"};
        vecs[3]  = '{3'b010, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32, "MULHSU"};
        vecs[4]  = '{3'b000, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 32, "MUL -1x2"};
        vecs[5]  = '{3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32, "DIV -7/2"};
        vecs[6]  = '{3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32, "REM -7/2"};
        vecs[7]  = '{3'b101, 32'd7,        32'd2,        32'd3,        32, "DIVU 7/2"};
        vecs[8]  = '{3'b111, 32'd7,        32'd2,        32'd1,        32, "REMU 7/2"};
        vecs[9]  = '{3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1,  "DIV 5/0"};
        vecs[10] = '{3'b110, 32'd5,        32'd0,        32'd5,        1,  "REM 5/0"};
        vecs[11] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  "DIV ovf"};
        vecs[12] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1,  "REM ovf"};

        bus.start = 1'b0; bus.op = 3'b000; bus.rd1 = '0; bus.rd2 = '0;
        #1 rst = 1'b1;
        #1;
        check("reset busy", {31'd0, bus.busy}, 32'd0);
        check("reset done", {31'd0, bus.done}, 32'd0);
        check("reset result", bus.result, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;

        for (int i = 0; i < 13; i++)
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, vecs[i].name, -1);

        // start during CALC must be ignored
        run_op(3'b000, 32'd9, 32'd10, 32'd90, 32, "MUL busy-start", 5);

        // start held high: second capture one IDLE cycle after done
        @(negedge clk);
        bus.op = 3'b000; bus.rd1 = 32'd3; bus.rd2 = 32'd4; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.rd2 = 32'd5;
        wait_done("held op1", lat);
        check("held op1 latency", 32'(lat), 32'd32);
        check("held op1 result", bus.result, 32'd12);
        @(posedge clk); #1;
        check("held idle busy", {31'd0, bus.busy}, 32'd0);
        check("held idle done", {31'd0, bus.done}, 32'd0);
        @(posedge clk); #1;
        check("held op2 capture", {31'd0, bus.busy}, 32'd1);
        bus.start = 1'b0;
        wait_done("held op2", lat);
        check("held op2 latency", 32'(lat), 32'd32);
        check("held op2 result", bus.result, 32'd15);
        $display("[TB] held-start pair -> result=%h", bus.result);
        @(posedge clk); #1;

        // asynchronous reset during iteration 10 of a DIVU
        @(negedge clk);
        bus.op = 3'b101; bus.rd1 = 32'd1000; bus.rd2 = 32'd7; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("midrst busy", {31'd0, bus.busy}, 32'd0);
        check("midrst done", {31'd0, bus.done}, 32'd0);
        check("midrst result", bus.result, 32'd0);
        @(negedge clk); rst = 1'b0;
        no_done = 1;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (bus.done) no_done = 0;
        end
        check("midrst no done", 32'(no_done), 32'd1);
        $display("[TB] DIVU aborted by reset -> result=%h", bus.result);

        run_op(3'b000, 32'd3, 32'd4, 32'd12, 32, "MUL 3x4 after reset", -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
